// File: rtl/imem_fetch.sv
// Instruction fetch stage: issues sequential SRAM word reads and buffers
// returned words with their PC for decode, restarting on redirect.
module imem_fetch #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_csb,
  output logic                  imem_web,
  output logic [3:0]            imem_wmask,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_din,
  input  logic [31:0]           imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_inst
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  fetch_ent_t            fifo [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         occ;
  logic [31:0]           fetch_pc;
  logic [31:0]           inflight_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic        deq;
  logic        push;
  logic        issue;
  logic [31:0] issue_pc;
  logic [CW:0] need;
  logic [CW:0] avail;

  assign imem_web   = 1'b1;
  assign imem_wmask = 4'b0000;
  assign imem_din   = 32'h0;

  assign out_valid = !reset && !redirect_valid && (occ != '0);
  assign deq       = out_valid && out_ready;
  assign push      = inflight && !redirect_valid && !reset;
  assign out_pc    = fifo[rd_ptr].pc;
  assign out_inst  = fifo[rd_ptr].inst;

  // Credit: entries held plus the read in flight plus this one must fit.
  assign need  = {1'b0, occ}
               + {{CW{1'b0}}, inflight}
               + {{CW{1'b0}}, 1'b1};
  assign avail = (CW+1)'(FIFO_DEPTH)
               + {{CW{1'b0}}, deq};

  assign issue    = !reset
                  && (redirect_valid || (need <= avail));
  assign issue_pc = redirect_valid
                  ? (redirect_pc & ~32'h3)
                  : fetch_pc;

  assign imem_csb  = !issue;
  assign imem_addr = issue
                   ? issue_pc[ADDR_WIDTH+1:2]
                   : addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      addr_q      <= RESET_PC[ADDR_WIDTH+1:2];
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo[i] <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= issue_pc + 32'd4;
        inflight_pc <= issue_pc;
        addr_q      <= issue_pc[ADDR_WIDTH+1:2];
      end else if (redirect_valid) begin
        fetch_pc <= issue_pc;
      end
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= '{pc: inflight_pc, inst: imem_dout};
          wr_ptr       <= wr_ptr + 1'b1;
        end
        if (deq)
          rd_ptr <= rd_ptr + 1'b1;
        occ <= occ + CW'(push) - CW'(deq);
      end
    end
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Instruction fetch stage sitting directly upstream of the instruction SRAM macro and downstream of the core's branch/jump redirect logic. Generates sequential word reads to the SRAM, captures returned instruction words into a small ordered buffer tagged with their PC, and presents them to decode over a valid/ready handshake. A redirect flushes the buffer, discards any read in flight, and restarts fetch at the new PC.

## Interface
Parameters:
- ADDR_WIDTH, 8: SRAM word-address width; SRAM holds 2^ADDR_WIDTH 32-bit words.
- RESET_PC, 32'h0000_0000: byte PC fetched first after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: instruction buffer entries; minimum 2, power of two.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_csb  out  1  SRAM chip select, active low; low = read issued this cycle.
- imem_web  out  1  SRAM write enable, active low; tied 1.
- imem_wmask  out  4  SRAM byte mask; tied 4'b0000.
- imem_addr  out  ADDR_WIDTH  SRAM word address = pc[ADDR_WIDTH+1:2].
- imem_din  out  32  SRAM write data; tied 0.
- imem_dout  in  32  SRAM read data; valid from mid-cycle in the cycle after issue.
- redirect_valid  in  1  restart fetch at redirect_pc this cycle.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored (treated as 0).
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_pc  out  32  byte PC of head instruction.
- out_inst  out  32  head instruction word.

## Operation
- State: fetch_pc (32b), inflight (1b), inflight_pc (32b), FIFO of {pc, inst}, FIFO_DEPTH entries, occupancy counter.
- deq = out_valid && out_ready.
- issue = !reset && (occ - deq + inflight + 1 <= FIFO_DEPTH). Credit rule guarantees every issued read has a FIFO slot on return; no read is ever dropped for lack of space.
- Issue PC: redirect_pc if redirect_valid, else fetch_pc. On issue: imem_csb=0, imem_addr from issue PC; fetch_pc <= issue PC + 4 (mod 2^32); inflight <= 1, inflight_pc <= issue PC. No issue: imem_csb=1, inflight <= 0; on redirect without issue fetch_pc <= redirect_pc.
- Return: when inflight=1 and no redirect this cycle, push {inflight_pc, imem_dout} into FIFO at end of cycle.
- Redirect (redirect_valid=1): FIFO cleared, current inflight response discarded, out_valid forced 0 this cycle (no dequeue occurs), read at redirect_pc issued same cycle if credit allows (always true after flush).
- Simultaneous push and pop: occupancy unchanged; FIFO order preserved.
- Address wrap: PC increments past 2^(ADDR_WIDTH+2) alias SRAM words modulo depth; out_pc carries full 32-bit PC.
- imem_addr/imem_csb are don't-care-free: imem_addr holds last value when csb=1.

## Timing
- Reset values: imem_csb=1, imem_web=1, imem_wmask=0, imem_din=0, out_valid=0, out_pc=0, out_inst=0, fetch_pc=RESET_PC, inflight=0, occ=0.
- First issue in first cycle with reset low (cycle 0, addr = RESET_PC word).
- Issue in cycle T -> FIFO write at end of T+1 -> out_valid in T+2. Fetch-to-decode latency 2 cycles.
- Steady state with out_ready=1: one instruction per cycle, FIFO_DEPTH=2 sufficient.
- out_ready low: at most FIFO_DEPTH instructions buffered; issue stops; out_pc/out_inst stable while out_valid && !out_ready.
- Redirect in cycle T: out_valid=0 in T and T+1; first redirected instruction out_valid in T+2.
- Reset asserted mid-stream: next cycle all state at reset values; inflight read ignored.

## Test plan
- Reset release, out_ready=1, SRAM word k = 0x1000+k: out_valid first in cycle 2 with pc 0x0/inst 0x1000, then pc 0x4, 0x8 each cycle, csb low every cycle.
- Backpressure: out_ready=0 from cycle 2 for 5 cycles: head stays pc 0x0, occ saturates at 2, csb high after credits exhausted; release -> pcs 0x0,0x4,0x8 consecutive, no gaps or duplicates.
- Redirect to 0x40 in cycle 5 of a stream: no pc 0x14/0x18 emitted after cycle 5; out_valid low cycles 5-6; cycle 7 pc 0x40 inst 0x1010.
- Redirect while stalled with full FIFO and redirect_pc=0x23: buffer flushed, next output pc 0x20.
- Wrap: redirect to 0x3F8 (ADDR_WIDTH=8): imem_addr 0xFE, 0xFF, 0x00; out_pc 0x3F8, 0x3FC, 0x400 with insts 0x10FE, 0x10FF, 0x1000.
- Reset pulsed for one cycle mid-stream with inflight=1: out_valid 0 next cycle, fetch restarts at RESET_PC, stale word never emitted.
